// File: rtl/axi_aw_arb_pkg.sv
// Shared constants for the AXI write-address arbiter: default widths and the
// two-state output-register encoding.
package axi_aw_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ID_W    = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_LEN_W   = 8;

  // Output register occupancy: EMPTY means m_awvalid=0, FULL means m_awvalid=1.
  typedef logic [0:0] aw_state_t;
  localparam aw_state_t ST_EMPTY = 1'b0;
  localparam aw_state_t ST_FULL  = 1'b1;

endpackage

// File: rtl/axi_aw_arbiter_if.sv
// Write-address bundle between NUM_REQ requesters, the arbiter and one
// downstream slave. The slave modport is the arbiter's view of the bundle.
interface axi_aw_arbiter_if
  import axi_aw_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        s_awvalid;
  logic [NUM_REQ-1:0]        s_awready;
  logic [NUM_REQ*ID_W-1:0]   s_awid;
  logic [NUM_REQ*ADDR_W-1:0] s_awaddr;
  logic [NUM_REQ*LEN_W-1:0]  s_awlen;
  logic                      m_awvalid;
  logic                      m_awready;
  logic [IDX_W+ID_W-1:0]     m_awid;
  logic [ADDR_W-1:0]         m_awaddr;
  logic [LEN_W-1:0]          m_awlen;
  logic [IDX_W-1:0]          grant_idx;

  modport slave (
    input  s_awvalid, s_awid, s_awaddr, s_awlen, m_awready,
    output s_awready, m_awvalid, m_awid, m_awaddr, m_awlen, grant_idx
  );

  modport master (
    output s_awvalid, s_awid, s_awaddr, s_awlen, m_awready,
    input  s_awready, m_awvalid, m_awid, m_awaddr, m_awlen, grant_idx
  );

endinterface

// File: rtl/axi_aw_arbiter_rr.sv
// Round-robin winner search with its rotating pointer. The search starts at
// ptr and wraps modulo NUM_REQ; the pointer moves past the winner on a grant.
module axi_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               open,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W:0]   cand_s;
  logic             found_s;
  logic [IDX_W-1:0] win_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] res;
    if (idx == IDX_W'(NUM_REQ - 1)) begin
      res = '0;
    end else begin
      res = idx + 1'b1;
    end
    return res;
  endfunction

  // First asserted request at or above ptr, wrapping around NUM_REQ.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, ptr_r} + (IDX_W+1)'(k);
      if (cand_s >= (IDX_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (IDX_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IDX_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = cand_s[IDX_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grants are suppressed while reset is asserted so no requester sees ready.
  assign grant_vld = open & found_s & rst;
  assign grant_idx = win_s;
  assign grant_oh  = {{(NUM_REQ-1){1'b0}}, grant_vld} << win_s;

  // Pointer advances past the winner only when a request is actually taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (grant_vld) begin
      ptr_r <= wrap_inc(win_s);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/axi_aw_arbiter.sv
// AXI write-address arbiter: round-robin selection among NUM_REQ requesters
// into a single registered output stage that sustains one transfer per cycle.
module axi_aw_arbiter
  import axi_aw_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  axi_aw_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  aw_state_t             state_r;
  logic [IDX_W+ID_W-1:0] id_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [LEN_W-1:0]      len_r;
  logic [IDX_W-1:0]      gidx_r;

  logic                  open_s;
  logic                  accept_s;
  logic [NUM_REQ-1:0]    grant_oh_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic [ID_W-1:0]       id_s;
  logic [ADDR_W-1:0]     addr_s;
  logic [LEN_W-1:0]      len_s;

  assign open_s = (state_r == ST_EMPTY) || bus.m_awready;

  axi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.s_awvalid),
    .open      (open_s),
    .grant_oh  (grant_oh_s),
    .grant_idx (win_idx_s),
    .grant_vld (accept_s)
  );

  // Payload mux: pick the winner's slice out of the packed request buses.
  always_comb begin
    id_s   = '0;
    addr_s = '0;
    len_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_s == IDX_W'(i)) begin
        id_s   = bus.s_awid[i*ID_W +: ID_W];
        addr_s = bus.s_awaddr[i*ADDR_W +: ADDR_W];
        len_s  = bus.s_awlen[i*LEN_W +: LEN_W];
      end else begin
        id_s   = id_s;
      end
    end
  end

  // Output register: reload on accept, drain on handshake, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_EMPTY;
      id_r    <= '0;
      addr_r  <= '0;
      len_r   <= '0;
      gidx_r  <= '0;
    end else if (accept_s) begin
      state_r <= ST_FULL;
      id_r    <= {win_idx_s, id_s};
      addr_r  <= addr_s;
      len_r   <= len_s;
      gidx_r  <= win_idx_s;
    end else if (open_s) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_r;
    end
  end

  assign bus.s_awready = grant_oh_s;
  assign bus.m_awvalid = (state_r == ST_FULL);
  assign bus.m_awid    = id_r;
  assign bus.m_awaddr  = addr_r;
  assign bus.m_awlen   = len_r;
  assign bus.grant_idx = gidx_r;

endmodule

// File: doc/axi_aw_arbiter.md
AXI_AW_ARBITER -- requirements
Module: axi_aw_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write-address requesters, legal range 2..8.
REQ-002 SHALL have parameter ID_W, default 4: requester awid width.
REQ-003 SHALL have parameter ADDR_W, default 32: awaddr width.
REQ-004 SHALL have parameter LEN_W, default 8: awlen width.
REQ-005 SHALL derive IDX_W = $clog2(NUM_REQ) as a localparam; it is not overridable.
REQ-006 clk  in  1  single clock; all state is updated on the rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 s_awvalid  in  NUM_REQ  per-requester valid.
REQ-009 s_awready  out  NUM_REQ  per-requester ready.
REQ-010 s_awid  in  NUM_REQ*ID_W  packed IDs; requester i occupies bits [i*ID_W +: ID_W].
REQ-011 s_awaddr  in  NUM_REQ*ADDR_W  packed addresses, packed the same way as s_awid.
REQ-012 s_awlen  in  NUM_REQ*LEN_W  packed burst lengths, packed the same way as s_awid.
REQ-013 m_awvalid  out  1  downstream valid.
REQ-014 m_awready  in  1  downstream ready.
REQ-015 m_awid  out  IDX_W+ID_W  {granted index, requester awid}.
REQ-016 m_awaddr  out  ADDR_W  address of the granted request.
REQ-017 m_awlen  out  LEN_W  burst length of the granted request.
REQ-018 grant_idx  out  IDX_W  index of the requester whose request is currently held in the output register; valid only while m_awvalid=1.

Function
REQ-019 The output register SHALL be "open" when m_awvalid=0, or when m_awvalid=1 and m_awready=1.
REQ-020 When the output register is open, the arbiter SHALL pick a winner by round-robin among the asserted s_awvalid bits, searching upward from pointer ptr modulo NUM_REQ.
REQ-021 s_awready[i] SHALL be asserted combinationally only when i is the winner and the output register is open; all other s_awready bits SHALL be 0.
REQ-022 Only the winner's s_awready SHALL depend on s_awvalid; s_awready SHALL never depend combinationally on m_awvalid of other blocks.
REQ-023 On an accept (s_awvalid[w] & s_awready[w]), on the next edge the block SHALL load m_awid={w,awid_w}, m_awaddr, m_awlen and grant_idx=w, set m_awvalid=1, and set ptr=(w+1) mod NUM_REQ.
REQ-024 Latency from accept to m_awvalid SHALL be exactly 1 cycle.
REQ-025 While m_awvalid=1 and m_awready=0, every m_* output and grant_idx SHALL hold stable, all s_awready bits SHALL be 0, and ptr SHALL hold.
REQ-026 A downstream handshake and a new accept in the same cycle SHALL reload the register with no bubble; sustained throughput SHALL be 1 txn/cycle.
REQ-027 A downstream handshake with no request pending SHALL clear m_awvalid on the next edge.
REQ-028 States: EMPTY (m_awvalid=0) and FULL (m_awvalid=1).
REQ-029 State transitions: EMPTY->FULL on accept; FULL->FULL on (handshake & accept) or no handshake; FULL->EMPTY on handshake without accept.
REQ-030 Fairness: a continuously asserted requester SHALL be granted within NUM_REQ accepts.
REQ-031 When s_awvalid is all zero, ptr SHALL be unchanged.
REQ-032 Pointer wrap: ptr at NUM_REQ-1 with winner NUM_REQ-1 SHALL become 0.
REQ-033 The block SHALL NOT modify awaddr or awlen; there is no length or address arithmetic.

Reset
REQ-034 On rst=0, asynchronously: m_awvalid=0, m_awid=0, m_awaddr=0, m_awlen=0, grant_idx=0, ptr=0, state=EMPTY.
REQ-035 s_awready SHALL be 0 while rst=0.
REQ-036 Reset mid-operation SHALL discard a held, un-handshaken transaction; it is not replayed.
REQ-037 The first arbitration after reset release SHALL start its search at index 0.

Structure
REQ-038 Package axi_aw_arb_pkg SHALL hold the state enum (EMPTY, FULL) and default width constants.
REQ-039 Sub-module axi_rr_arbiter SHALL contain the round-robin winner search, the ptr register, and a one-hot/index output.
REQ-040 axi_aw_arbiter SHALL contain the payload mux and the output register.

Verification
REQ-041 Reset release, s_awvalid=4'b0000 -> m_awvalid stays 0; ptr=0.
REQ-042 s_awvalid=4'b1111, m_awready=1 held -> grant order 0,1,2,3,0; m_awvalid=1 every cycle after the first.
REQ-043 Only requester 2 valid, awid=4'hA, awaddr=32'h1000, awlen=3 -> one cycle later m_awid=6'h2A, m_awaddr=32'h1000, m_awlen=3, grant_idx=2.
REQ-044 m_awready=0 for 5 cycles with register FULL -> m_* outputs stable, s_awready=0 for all 5 cycles; handshake on cycle 6.
REQ-045 Requester 3 valid with ptr=3, then requesters 0 and 3 both valid -> grants 3, then 0 (wrap).
REQ-046 rst asserted while FULL and m_awready=0 -> m_awvalid=0 immediately; after release, the next grant searches from index 0.
